// File: rtl/mem_pkg.sv
// ============================================================================
// Module : mem_pkg
// Brief  : Shared types and constants for the memory port scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam int LINE_W = 512;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        HOLD  = 3'd4
    } sched_state_t;

    typedef enum logic {
        GNT_IC = 1'b0,
        GNT_DC = 1'b1
    } grant_t;

    function automatic grant_t other_grant(input grant_t g);
        return (g == GNT_IC) ? GNT_DC : GNT_IC;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
// ============================================================================
// Module : rr_pick2
// Brief  : Combinational two-way pick between icache and dcache requesters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick2 #(
    parameter int DC_PRIO = 1
) (
    input  logic ic_req,
    input  logic dc_req,
    input  logic last_dc,
    input  logic streak_hit,
    output logic grant_dc
);
    import mem_pkg::*;

    grant_t w_last;
    grant_t w_pick;

    assign w_last   = last_dc ? GNT_DC : GNT_IC;
    assign grant_dc = (w_pick == GNT_DC);

    always_comb begin
        w_pick = GNT_IC;
        if (dc_req && !ic_req) begin
            w_pick = GNT_DC;
        end else if (dc_req && ic_req) begin
            // A saturated streak hands the port to whoever has been waiting.
            if (streak_hit) begin
                w_pick = other_grant(w_last);
            end else if (DC_PRIO != 0) begin
                w_pick = GNT_DC;
            end else begin
                w_pick = other_grant(w_last);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_scheduler.sv
// ============================================================================
// Module : mem_port_scheduler
// Brief  : Shares one memory line port between icache and dcache miss engines.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_scheduler #(
    parameter int ADDR_W     = 64,
    parameter int LINE_W     = 512,
    parameter int LINE_OFF   = 6,
    parameter int DC_PRIO    = 1,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic [LINE_W-1:0] ic_data,
    output logic              ic_done,
    input  logic              dc_req,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic              dc_wr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic [LINE_W-1:0] dc_data,
    output logic              dc_done,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic              busy
);
    import mem_pkg::*;

    localparam int                STREAK_W   = $clog2(MAX_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);
    localparam logic [ADDR_W-1:0] ADDR_MASK  = {{(ADDR_W-LINE_OFF){1'b1}}, {LINE_OFF{1'b0}}};

    sched_state_t        state_q,      state_d;
    grant_t              last_grant_q, last_grant_d;
    logic [STREAK_W-1:0] streak_q,     streak_d;
    logic                mem_req_q,    mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
    logic                mem_wr_q,     mem_wr_d;
    logic [LINE_W-1:0]   mem_wdata_q,  mem_wdata_d;
    logic [LINE_W-1:0]   ic_data_q,    ic_data_d;
    logic [LINE_W-1:0]   dc_data_q,    dc_data_d;
    logic                ic_done_q,    ic_done_d;
    logic                dc_done_q,    dc_done_d;
    logic                busy_q,       busy_d;

    logic                w_pick_dc;
    grant_t              w_pick;

    rr_pick2 #(
        .DC_PRIO    (DC_PRIO)
    ) u_pick (
        .ic_req     (ic_req),
        .dc_req     (dc_req),
        .last_dc    (last_grant_q == GNT_DC),
        .streak_hit (streak_q == STREAK_MAX),
        .grant_dc   (w_pick_dc)
    );

    assign w_pick = w_pick_dc ? GNT_DC : GNT_IC;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        streak_d     = streak_q;
        mem_req_d    = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wr_d     = mem_wr_q;
        mem_wdata_d  = mem_wdata_q;
        ic_data_d    = ic_data_q;
        dc_data_d    = dc_data_q;
        ic_done_d    = 1'b0;
        dc_done_d    = 1'b0;
        busy_d       = busy_q;

        case (state_q)
            IDLE: begin
                if (ic_req || dc_req) begin
                    state_d      = ISSUE;
                    busy_d       = 1'b1;
                    mem_req_d    = 1'b1;
                    last_grant_d = w_pick;
                    // Streak only grows when the same side wins over a waiting rival.
                    if ((w_pick == last_grant_q) && ic_req && dc_req) begin
                        streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + STREAK_W'(1);
                    end else begin
                        streak_d = STREAK_W'(1);
                    end
                    if (w_pick == GNT_DC) begin
                        mem_addr_d  = dc_addr & ADDR_MASK;
                        mem_wr_d    = dc_wr;
                        mem_wdata_d = dc_wdata;
                    end else begin
                        mem_addr_d  = ic_addr & ADDR_MASK;
                        mem_wr_d    = 1'b0;
                        mem_wdata_d = '0;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (mem_valid) begin
                    state_d = DONE;
                    if (last_grant_q == GNT_DC) begin
                        dc_done_d = 1'b1;
                        if (!mem_wr_q) begin
                            dc_data_d = mem_rdata;
                        end
                    end else begin
                        ic_done_d = 1'b1;
                        ic_data_d = mem_rdata;
                    end
                end
            end
            DONE: begin
                state_d = HOLD;
            end
            HOLD: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_IC;
            streak_q     <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wr_q     <= 1'b0;
            mem_wdata_q  <= '0;
            ic_data_q    <= '0;
            dc_data_q    <= '0;
            ic_done_q    <= 1'b0;
            dc_done_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            streak_q     <= streak_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_wr_q     <= mem_wr_d;
            mem_wdata_q  <= mem_wdata_d;
            ic_data_q    <= ic_data_d;
            dc_data_q    <= dc_data_d;
            ic_done_q    <= ic_done_d;
            dc_done_q    <= dc_done_d;
            busy_q       <= busy_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;
    assign ic_data   = ic_data_q;
    assign dc_data   = dc_data_q;
    assign ic_done   = ic_done_q;
    assign dc_done   = dc_done_q;
    assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_scheduler.sv
// ============================================================================
// Module : tb_mem_port_scheduler
// Brief  : Scoreboard bench for mem_port_scheduler with a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_port_scheduler;

    localparam int ADDR_W     = 64;
    localparam int LINE_W     = 512;
    localparam int LINE_OFF   = 6;
    localparam int DC_PRIO    = 1;
    localparam int MAX_STREAK = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              ic_req = 1'b0;
    logic [ADDR_W-1:0] ic_addr = '0;
    logic [LINE_W-1:0] ic_data;
    logic              ic_done;
    logic              dc_req = 1'b0;
    logic [ADDR_W-1:0] dc_addr = '0;
    logic              dc_wr = 1'b0;
    logic [LINE_W-1:0] dc_wdata = '0;
    logic [LINE_W-1:0] dc_data;
    logic              dc_done;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata = '0;
    logic              mem_valid = 1'b0;
    logic              busy;

    mem_port_scheduler #(
        .ADDR_W(ADDR_W), .LINE_W(LINE_W), .LINE_OFF(LINE_OFF),
        .DC_PRIO(DC_PRIO), .MAX_STREAK(MAX_STREAK)
    ) dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_data(ic_data), .ic_done(ic_done),
        .dc_req(dc_req), .dc_addr(dc_addr), .dc_wr(dc_wr), .dc_wdata(dc_wdata),
        .dc_data(dc_data), .dc_done(dc_done),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                is_dc;
        logic [ADDR_W-1:0] addr;
        logic              wr;
        logic [LINE_W-1:0] wdata;
        int                cyc;
    } issue_t;

    typedef struct {
        bit                is_dc;
        logic [LINE_W-1:0] data;
        int                cyc;
    } done_t;

    issue_t iq[$];
    done_t  dq[$];
    issue_t cur;
    bit     in_txn = 0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int epoch = 0;
    int n_issued = 0;
    int n_done = 0;
    int n_aborted = 0;
    int ic_done_cnt = 0;
    int dc_done_cnt = 0;
    int dc_at_ic = 0;

    // Reference state: who was served last, how many times in a row.
    bit                m_last_dc = 0;
    int                m_streak = 0;
    logic [LINE_W-1:0] last_dc_fill = '0;
    logic [LINE_W-1:0] last_ic_data = '0;

    bit                resp_hold = 0;
    bit                use_fixed = 0;
    logic [LINE_W-1:0] fixed_rdata = '0;

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got event want none", name);
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] r;
        for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr();
        return {$urandom, $urandom};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference model: arbitrate whenever the scheduler is idle and someone asks.
    initial begin
        bit     win_dc;
        issue_t e;
        forever begin
            @(negedge clk);
            if (rst && !busy && (ic_req || dc_req)) begin
                if (ic_req && dc_req) begin
                    if (m_streak == MAX_STREAK) win_dc = !m_last_dc;
                    else win_dc = (DC_PRIO != 0) ? 1'b1 : !m_last_dc;
                    if (win_dc == m_last_dc) m_streak = (m_streak < MAX_STREAK) ? m_streak + 1 : m_streak;
                    else m_streak = 1;
                end else begin
                    win_dc   = dc_req;
                    m_streak = 1;
                end
                m_last_dc = win_dc;
                e.is_dc = win_dc;
                e.addr  = (win_dc ? dc_addr : ic_addr) & ~((64'd1 << LINE_OFF) - 64'd1);
                e.wr    = win_dc & dc_wr;
                e.wdata = win_dc ? dc_wdata : '0;
                e.cyc   = cyc + 1;
                iq.push_back(e);
            end
        end
    end

    // Issue monitor: start pulse contents and stability while outstanding.
    initial forever begin
        @(negedge clk);
        if (mem_req) begin
            if (iq.size() == 0) begin
                fail_now("spurious_mem_req");
            end else begin
                cur = iq.pop_front();
                n_issued++;
                in_txn = 1;
                chk("mem_req_latency", LINE_W'(cyc), LINE_W'(cur.cyc));
                chk("mem_addr", LINE_W'(mem_addr), LINE_W'(cur.addr));
                chk("mem_wr", LINE_W'(mem_wr), LINE_W'(cur.wr));
                chk("mem_wdata", mem_wdata, cur.wdata);
                chk("busy_issue", LINE_W'(busy), LINE_W'(1));
            end
        end else if (in_txn) begin
            chk("mem_addr_hold", LINE_W'(mem_addr), LINE_W'(cur.addr));
            chk("mem_wr_hold", LINE_W'(mem_wr), LINE_W'(cur.wr));
            chk("mem_wdata_hold", mem_wdata, cur.wdata);
        end
    end

    // Done monitor.
    initial begin
        done_t e;
        forever begin
            @(negedge clk);
            if (ic_done || dc_done) begin
                if (dq.size() == 0) begin
                    fail_now("spurious_done");
                end else begin
                    e = dq.pop_front();
                    n_done++;
                    in_txn = 0;
                    chk("done_port_dc", LINE_W'(dc_done), LINE_W'(e.is_dc));
                    chk("done_port_ic", LINE_W'(ic_done), LINE_W'(!e.is_dc));
                    chk("done_latency", LINE_W'(cyc), LINE_W'(e.cyc));
                    if (e.is_dc) chk("dc_data", dc_data, e.data);
                    else         chk("ic_data", ic_data, e.data);
                end
                if (dc_done) dc_done_cnt++;
                if (ic_done) begin
                    ic_done_cnt++;
                    dc_at_ic = dc_done_cnt;
                end
            end
        end
    end

    // Memory controller responder.
    initial begin
        int                ep;
        int                d;
        done_t             e;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                ep = epoch;
                d  = $urandom_range(1, 3);
                repeat (d) @(posedge clk);
                while (resp_hold) @(posedge clk);
                #2;
                mem_rdata = use_fixed ? fixed_rdata : rand_line();
                mem_valid = 1'b1;
                if (ep == epoch) begin
                    e.is_dc = cur.is_dc;
                    e.cyc   = cyc + 1;
                    if (!cur.is_dc) begin
                        e.data = mem_rdata;
                        last_ic_data = mem_rdata;
                    end else if (!cur.wr) begin
                        e.data = mem_rdata;
                        last_dc_fill = mem_rdata;
                    end else begin
                        e.data = last_dc_fill;
                    end
                    dq.push_back(e);
                end
                @(posedge clk);
                #2 mem_valid = 1'b0;
            end
        end
    end

    task automatic flush();
        if (in_txn) n_aborted++;
        iq.delete();
        dq.delete();
        in_txn       = 0;
        m_last_dc    = 0;
        m_streak     = 0;
        last_dc_fill = '0;
        last_ic_data = '0;
        epoch++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},      LINE_W'(busy),     '0);
        chk({tag, "_mem_req"},   LINE_W'(mem_req),  '0);
        chk({tag, "_mem_addr"},  LINE_W'(mem_addr), '0);
        chk({tag, "_mem_wr"},    LINE_W'(mem_wr),   '0);
        chk({tag, "_mem_wdata"}, mem_wdata,         '0);
        chk({tag, "_ic_done"},   LINE_W'(ic_done),  '0);
        chk({tag, "_dc_done"},   LINE_W'(dc_done),  '0);
        chk({tag, "_ic_data"},   ic_data,           '0);
        chk({tag, "_dc_data"},   dc_data,           '0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        ic_req = 1'b0;
        dc_req = 1'b0;
        rst    = 1'b0;
        flush();
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic ic_txn(input logic [ADDR_W-1:0] a, input bit chg);
        bit seen;
        seen = 0;
        @(posedge clk);
        #2;
        ic_req  = 1'b1;
        ic_addr = a;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ic_done) begin
                seen = 1;
                break;
            end
            if (chg && busy) ic_addr = rand_addr();
        end
        if (!seen) fail_now("ic_done_timeout");
        @(posedge clk);
        #2 ic_req = 1'b0;
    endtask

    task automatic dc_txn(input logic [ADDR_W-1:0] a, input logic wr, input logic [LINE_W-1:0] wd);
        bit seen;
        seen = 0;
        @(posedge clk);
        #2;
        dc_req   = 1'b1;
        dc_addr  = a;
        dc_wr    = wr;
        dc_wdata = wd;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (dc_done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) fail_now("dc_done_timeout");
        @(posedge clk);
        #2 dc_req = 1'b0;
    endtask

    initial begin
        logic [LINE_W-1:0] wd;
        int                d0;
        bit                seen;

        rst = 1'b0;
        @(negedge clk);
        chk_zero("por");
        do_reset();

        // Single icache fill with a known line.
        use_fixed   = 1;
        fixed_rdata = {64{8'hA5}};
        ic_txn(64'h1_0047, 0);
        use_fixed = 0;

        // dcache fill then write-back: write must leave dc_data alone.
        dc_txn(64'h2000_0123, 1'b0, rand_line());
        wd = {8{64'hDEAD_BEEF}};
        dc_txn(64'h3000_00FF, 1'b1, wd);

        // Continuous dcache pressure against a waiting icache.
        do_reset();
        d0 = dc_done_cnt;
        fork
            ic_txn(64'h4000_0040, 0);
            for (int k = 0; k < 5; k++) dc_txn(64'h5000_0000 + 64'(k * 64), 1'b0, '0);
        join
        chk("streak_dc_before_ic", LINE_W'(dc_at_ic - d0), LINE_W'(MAX_STREAK));

        // Address churn after grant, then a stray mem_valid while idle.
        ic_txn(64'h6000_0080, 1);
        repeat (3) @(posedge clk);
        #2;
        mem_rdata = rand_line();
        mem_valid = 1'b1;
        @(posedge clk);
        #2 mem_valid = 1'b0;
        @(negedge clk);
        chk("stray_busy", LINE_W'(busy), '0);
        chk("stray_ic_data", ic_data, last_ic_data);
        chk("stray_dc_data", dc_data, last_dc_fill);

        // Reset asserted while waiting on memory.
        resp_hold = 1;
        @(posedge clk);
        #2;
        ic_req  = 1'b1;
        ic_addr = rand_addr();
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req) begin
                seen = 1;
                break;
            end
        end
        if (!seen) fail_now("rst_test_mem_req_timeout");
        @(posedge clk);
        #2;
        chk("wait_busy", LINE_W'(busy), LINE_W'(1));
        rst    = 1'b0;
        ic_req = 1'b0;
        flush();
        @(negedge clk);
        chk_zero("midrst");
        @(posedge clk);
        #2;
        rst       = 1'b1;
        resp_hold = 0;
        repeat (6) @(posedge clk);
        ic_txn(rand_addr(), 0);

        // Randomized mixed traffic.
        for (int r = 0; r < 40; r++) begin
            fork
                begin
                    if ($urandom_range(0, 3) != 0) ic_txn(rand_addr(), 0);
                end
                begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    if ($urandom_range(0, 3) != 0) dc_txn(rand_addr(), 1'($urandom_range(0, 1)), rand_line());
                end
            join
        end

        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("issue_q_empty", LINE_W'(iq.size()), '0);
        chk("done_q_empty", LINE_W'(dq.size()), '0);
        chk("done_per_grant", LINE_W'(n_done), LINE_W'(n_issued - n_aborted));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
